debounce_edge_detect: RTL
=========================

Name: debounce_edge_detect

Overview:
- Cleans a raw, asynchronous single-bit input before it is registered by the rising-edge D flip-flop stage.
- Three functions: synchronises the input through a flop chain, rejects glitches shorter than a programmable number of clock cycles, and emits a clean level plus one-cycle rise/fall pulses.
- Sits directly upstream of the D flip-flop stage; its Q output drives that stage's D input.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range 2..4.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a new level; legal range 2..255.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width; derived, not overridden.

Ports:
- clk  input  1  main clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- D  input  1  raw asynchronous data line
- Q  output  1  debounced, registered level
- rise  output  1  one-cycle pulse, registered, when Q goes 0->1
- fall  output  1  one-cycle pulse, registered, when Q goes 1->0
- busy  output  1  high while a candidate level change is being qualified

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high, named rst.
- Reset values (asserted asynchronously, immediately on rst):
  - sync chain all 0; state STABLE_LOW; counter 0.
  - Q=0, rise=0, fall=0, busy=0.
- Synchroniser:
  - D passes through SYNC_STAGES flops; the last flop is s.
  - No logic acts on D before the final flop.
- FSM states: STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW.
- STABLE_LOW:
  - s=1 -> PEND_HIGH, cnt<=1.
  - Otherwise hold, cnt<=0.
- PEND_HIGH:
  - s=0 -> STABLE_LOW, cnt<=0 (glitch rejected, no pulse).
  - s=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HIGH, Q<=1, rise<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- STABLE_HIGH / PEND_LOW: mirror of the above with s=0; completing PEND_LOW gives Q<=0, fall<=1.
- rise and fall:
  - High for exactly one cycle; cleared on the next edge unconditionally.
  - Never both high at once.
- busy is 1 exactly when the state is PEND_HIGH or PEND_LOW; it is registered together with the state.
- Latency:
  - D stable at 1 from before edge k -> Q=1 and rise=1 after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - Defaults: k+5.
- Acceptance threshold:
  - D held for exactly DEBOUNCE_CYCLES sampled edges -> accepted.
  - DEBOUNCE_CYCLES-1 edges -> rejected.
- A reversal on the qualifying edge itself (s flips when cnt==DEBOUNCE_CYCLES-1) -> rejected; the FSM returns to the stable state.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Reset mid-qualification or mid-pulse:
  - Everything returns to reset values immediately.
  - No fall pulse is generated for Q dropping due to reset.
- First edge after rst deasserts: normal operation; D already high at release qualifies like any 0->1 change.

Decomposition:
- Shared package debounce_pkg:
  - state enum (2-bit encoding: STABLE_LOW=0, PEND_HIGH=1, STABLE_HIGH=2, PEND_LOW=3).
  - localparam bounds for SYNC_STAGES and DEBOUNCE_CYCLES.
  - Elaboration-time parameter check.
- Sub-module sync_chain:
  - Parameterised SYNC_STAGES-deep shift of rising-edge D flip-flops with async active-high reset to 0.
  - Reusable by other clock-domain inputs.
- FSM, counter and pulse registers live in the top module.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, clk period 20, rst high 0..25):
- Clean rise: D=1 set before edge at t=50 and held -> Q=1 and rise=1 after edge t=150 only; rise=0 after t=170; busy high after edges t=90..130.
- Glitch: D=1 for 3 sampled edges, then 0 -> Q stays 0; rise never asserted; busy returns to 0; FSM back to STABLE_LOW.
- Threshold: D=1 for exactly 4 sampled edges, then 0 -> Q=1 with one rise pulse, then fall 4 cycles after s returns to 0.
- Bouncing: D toggles at 1-cycle intervals for 10 cycles, then settles at 1 -> single rise only, 5 edges after settling; no fall.
- Reset mid-qualification: rst asserted while busy=1 in PEND_LOW with Q=1 -> Q=0, busy=0 immediately (between edges); no fall pulse.
- Random-delay stimulus: D driven with $random 0..7-cycle delays for 200 cycles -> rise/fall counts alternate, never both high, and match a reference model.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types, parameter bounds and elaboration check for debounce_edge_detect.
`default_nettype none

package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      PEND_HIGH   = 2'd1,
      STABLE_HIGH = 2'd2,
      PEND_LOW    = 2'd3
   } state_t;

   localparam int SYNC_STAGES_MIN     = 2;
   localparam int SYNC_STAGES_MAX     = 4;
   localparam int DEBOUNCE_CYCLES_MIN = 2;
   localparam int DEBOUNCE_CYCLES_MAX = 255;

   function automatic bit params_ok(input int sync_stages, input int debounce_cycles);
      return (sync_stages >= SYNC_STAGES_MIN) && (sync_stages <= SYNC_STAGES_MAX) &&
             (debounce_cycles >= DEBOUNCE_CYCLES_MIN) &&
             (debounce_cycles <= DEBOUNCE_CYCLES_MAX);
   endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_edge_detect_sync_chain.sv
// sync_chain: STAGES-deep flop chain bringing an asynchronous bit into the clk domain.
`default_nettype none

module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
      end else begin
         sr <= {sr[STAGES-2:0], d};
      end
   end

   assign q = sr[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/debounce_edge_detect.sv
// debounce_edge_detect: synchronise, debounce and edge-detect a raw asynchronous input.
`default_nettype none

module debounce_edge_detect
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic D,
   output logic Q,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   generate
      if (!params_ok(SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_param_check
         $error("debounce_edge_detect: SYNC_STAGES or DEBOUNCE_CYCLES out of range");
      end
   endgenerate

   logic             s;
   state_t           state;
   logic [CNT_W-1:0] cnt;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (D),
      .q   (s)
   );

   // Pulses default low every cycle; only a completed qualification raises one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= STABLE_LOW;
         cnt   <= '0;
         Q     <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            STABLE_LOW: begin
               if (s) begin
                  state <= PEND_HIGH;
                  cnt   <= CNT_ONE;
                  busy  <= 1'b1;
               end else begin
                  cnt   <= '0;
               end
            end
            PEND_HIGH: begin
               if (!s) begin
                  state <= STABLE_LOW;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state <= STABLE_HIGH;
                  cnt   <= '0;
                  busy  <= 1'b0;
                  Q     <= 1'b1;
                  rise  <= 1'b1;
               end else begin
                  cnt   <= cnt + CNT_ONE;
               end
            end
            STABLE_HIGH: begin
               if (!s) begin
                  state <= PEND_LOW;
                  cnt   <= CNT_ONE;
                  busy  <= 1'b1;
               end else begin
                  cnt   <= '0;
               end
            end
            PEND_LOW: begin
               if (s) begin
                  state <= STABLE_HIGH;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state <= STABLE_LOW;
                  cnt   <= '0;
                  busy  <= 1'b0;
                  Q     <= 1'b0;
                  fall  <= 1'b1;
               end else begin
                  cnt   <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= STABLE_LOW;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
